rv32i_multicycle_ctrl: RTL and testbench

RV32I_MULTICYCLE_CTRL -- requirements
Module: rv32i_multicycle_ctrl

---
 rtl/rv32i_multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle control FSM for an RV32I core: sequences fetch, decode, execute, memory and
// writeback over handshaked memories, and traps on illegal opcodes or memory timeouts.
module rv32i_multicycle_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       WAIT_MAX = 15,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic [31:0]       alu_result,
    input  logic              branch_taken,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic              reg_we,
    output logic [2:0]        state,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [CNT_W-1:0]  retired
);

    localparam int unsigned WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(WAIT_MAX);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [CNT_W-1:0]    ret_q, ret_d;
    logic [1:0]          cause_q, cause_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    // Set once en has been sampled high in FETCH; makes imem_req a pure register decode.
    logic                run_q, run_d;

    logic [6:0]          opcode;
    logic                is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
    logic [ADDR_W-1:0]   pc_plus4, alu_addr;

    assign opcode   = ir_q[6:0];
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign alu_addr = alu_result[ADDR_W-1:0];

    always_comb begin
        is_load   = (opcode == OpLoad);
        is_store  = (opcode == OpStore);
        is_branch = (opcode == OpBranch);
        is_jal    = (opcode == OpJal);
        is_jalr   = (opcode == OpJalr);
        is_legal  = is_load || is_store || is_branch || is_jal || is_jalr ||
                    (opcode == OpLui) || (opcode == OpAuipc) ||
                    (opcode == OpReg) || (opcode == OpImm);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        cause_d = cause_q;
        wait_d  = wait_q;
        run_d   = run_q;
        unique case (state_q)
            StFetch: begin
                if (!run_q) begin
                    run_d = en;
                end else if (imem_valid) begin
                    ir_d    = imem_rdata;
                    run_d   = 1'b0;
                    state_d = StDecode;
                end else if (wait_q == WaitLast) begin
                    cause_d = 2'b10;
                    run_d   = 1'b0;
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StDecode: begin
                if (is_legal) begin
                    state_d = StExec;
                end else begin
                    cause_d = 2'b01;
                    state_d = StTrap;
                end
            end
            StExec: begin
                if (is_load || is_store) begin
                    wait_d  = '0;
                    state_d = StMem;
                end else if (is_branch) begin
                    pc_d    = branch_taken ? alu_addr : pc_plus4;
                    ret_d   = ret_q + CNT_W'(1);
                    wait_d  = '0;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_d    = pc_plus4;
                        ret_d   = ret_q + CNT_W'(1);
                        wait_d  = '0;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_q == WaitLast) begin
                    cause_d = 2'b11;
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StWb: begin
                if (is_jal) begin
                    pc_d = alu_addr;
                end else if (is_jalr) begin
                    pc_d = alu_addr & ~ADDR_W'(1);
                end else begin
                    pc_d = pc_plus4;
                end
                ret_d   = ret_q + CNT_W'(1);
                wait_d  = '0;
                state_d = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ret_q   <= '0;
            cause_q <= '0;
            wait_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            run_q   <= run_d;
        end
    end

    assign imem_req   = (state_q == StFetch) && run_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == StMem);
    assign dmem_we    = (state_q == StMem) && is_store;
    assign reg_we     = (state_q == StWb);
    assign trap       = (state_q == StTrap);
    assign trap_cause = cause_q;
    assign state      = state_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign retired    = ret_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: directed vector table, hand sequences for reset/enable,
// and randomized instruction streams checked against an instruction-level reference model.
module tb_rv32i_multicycle_ctrl;

    localparam int          TB_WAIT_MAX = 15;
    localparam logic [31:0] TB_RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready = 1'b0;
    logic [31:0] alu_result = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        reg_we;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;

    rv32i_multicycle_ctrl #(
        .ADDR_W  (32),
        .RESET_PC(TB_RESET_PC),
        .WAIT_MAX(TB_WAIT_MAX),
        .CNT_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .alu_result  (alu_result),
        .branch_taken(branch_taken),
        .pc          (pc),
        .ir          (ir),
        .reg_we      (reg_we),
        .state       (state),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ret;
        logic [7:0]  wb;
        logic [7:0]  we;
        logic [2:0]  st;
        logic [1:0]  cause;
        logic [7:0]  cyc;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] alu;
        logic        bt;
        int          di;
        int          dd;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_trap;

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                                   7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011};

    task automatic chk(input string grp, input string what, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", grp, what, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] instr, input logic [31:0] alu, input logic bt,
                           input int di, input int dd, input logic [31:0] e_pc,
                           input logic [31:0] e_ret, input int e_wb, input int e_we,
                           input int e_st, input int e_cause, input int e_cyc);
        vec_t v;
        v.instr = instr; v.alu = alu; v.bt = bt; v.di = di; v.dd = dd;
        v.e.pc = e_pc; v.e.ret = e_ret; v.e.wb = 8'(e_wb); v.e.we = 8'(e_we);
        v.e.st = 3'(e_st); v.e.cause = 2'(e_cause); v.e.cyc = 8'(e_cyc);
        vecs.push_back(v);
    endtask

    // Instruction-level model: outcome and cycle cost of one instruction from the
    // architectural rules, given the memory response delays the bench will apply.
    task automatic predict(input logic [31:0] instr, input logic [31:0] alu, input logic bt,
                           input int di, input int dd, output exp_t e);
        logic [6:0] op;
        bit legal;
        int cyc;
        op = instr[6:0];
        legal = 0;
        foreach (legal_ops[k]) if (legal_ops[k] == op) legal = 1;
        e.pc = m_pc; e.ret = m_ret; e.wb = 0; e.we = 0; e.st = 0; e.cause = 0;
        if (di > TB_WAIT_MAX) begin
            e.st = 5; e.cause = 2; e.cyc = 8'(1 + TB_WAIT_MAX + 1);
            return;
        end
        cyc = 1 + di + 1;
        if (!legal) begin
            e.st = 5; e.cause = 1; e.cyc = 8'(cyc + 1);
            return;
        end
        cyc += 2;
        if (op == 7'b1100011) begin
            e.pc = bt ? alu : m_pc + 32'd4;
            e.ret = m_ret + 1;
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            if (dd > TB_WAIT_MAX) begin
                e.we = (op == 7'b0100011) ? 8'(TB_WAIT_MAX + 1) : 8'd0;
                e.st = 5; e.cause = 3;
                cyc += TB_WAIT_MAX + 1;
            end else begin
                cyc += dd + 1;
                e.pc = m_pc + 32'd4;
                e.ret = m_ret + 1;
                if (op == 7'b0100011) e.we = 8'(dd + 1);
                else begin e.wb = 1; cyc += 1; end
            end
        end else begin
            cyc += 1;
            e.wb = 1;
            e.ret = m_ret + 1;
            if (op == 7'b1101111) e.pc = alu;
            else if (op == 7'b1100111) e.pc = alu & ~32'd1;
            else e.pc = m_pc + 32'd4;
        end
        e.cyc = 8'(cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; imem_valid = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        chk("reset", "outs", {state, pc, ir, retired, trap, trap_cause, imem_req, dmem_req,
            dmem_we, reg_we}, {3'd0, TB_RESET_PC, 32'd0, 32'd0, 1'b0, 2'b00, 4'b0000});
        rst = 1'b0;
        m_pc = TB_RESET_PC; m_ret = 0; m_trap = 0;
    endtask

    // Acts as both memories for one instruction, starting at a negedge in idle FETCH.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] alu, input logic bt,
                             input int di, input int dd, input logic [31:0] pc0,
                             output int cyc, output int wbn, output int wen, output int bad,
                             output bit to);
        int rq, mq;
        bit left, done;
        rq = 0; mq = 0; cyc = 0; wbn = 0; wen = 0; bad = 0; to = 0; left = 0; done = 0;
        imem_rdata = instr; alu_result = alu; branch_taken = bt; en = 1'b1;
        while (!done) begin
            if (state == 3'd5 || (left && state == 3'd0)) begin
                done = 1;
            end else begin
                if (state != 3'd0) left = 1;
                if (imem_req) begin
                    if (imem_addr !== pc0) bad++;
                    imem_valid = (rq == di);
                    rq++;
                end else imem_valid = 1'b0;
                if (dmem_req) begin
                    dmem_ready = (mq == dd);
                    if (dmem_we) wen++;
                    mq++;
                end else dmem_ready = 1'b0;
                if (reg_we) wbn++;
                @(negedge clk);
                cyc++;
                if (cyc > 300) begin to = 1; done = 1; end
            end
        end
        imem_valid = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic apply(input string name, input logic [31:0] instr, input logic [31:0] alu,
                         input logic bt, input int di, input int dd, input logic [31:0] pc0,
                         input exp_t e);
        int cyc, wbn, wen, bad;
        bit to;
        run_instr(instr, alu, bt, di, dd, pc0, cyc, wbn, wen, bad, to);
        chk(name, "timeout", to, 1'b0);
        chk(name, "pc", pc, e.pc);
        chk(name, "retired", retired, e.ret);
        chk(name, "state_trap_cause", {state, trap, trap_cause}, {e.st, e.st == 3'd5, e.cause});
        chk(name, "reg_we_pulses", wbn, e.wb);
        chk(name, "dmem_we_cycles", wen, e.we);
        chk(name, "cycles", cyc, e.cyc);
        chk(name, "imem_addr", bad, 0);
        if (!(e.st == 3'd5 && e.cause == 2'b10)) chk(name, "ir", ir, instr);
        if (e.st == 3'd5) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk(name, "sticky", {state, trap, trap_cause, imem_req, dmem_req, reg_we, pc,
                    retired}, {3'd5, 1'b1, e.cause, 3'b000, e.pc, e.ret});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [31:0] instr;
        int di, dd;

        //       instr         alu           bt  di  dd  pc           ret wb we st cs cyc
        add_vec(32'h00100093, 32'h00001234, 0,  1,  0, 32'h4,        1,  1, 0, 0, 0, 6);
        add_vec(32'h00000063, 32'h00000040, 1,  0,  0, 32'h40,       1,  0, 0, 0, 0, 4);
        add_vec(32'h00000063, 32'h00000040, 0,  0,  0, 32'h4,        1,  0, 0, 0, 0, 4);
        add_vec(32'h00002083, 32'h00001000, 0,  0,  3, 32'h4,        1,  1, 0, 0, 0, 9);
        add_vec(32'h00112023, 32'h00001000, 0,  0,  0, 32'h4,        1,  0, 1, 0, 0, 5);
        add_vec(32'h00112023, 32'h00001000, 0,  0,  2, 32'h4,        1,  0, 3, 0, 0, 7);
        add_vec(32'h0000007F, 32'h00000000, 0,  0,  0, 32'h0,        0,  0, 0, 5, 1, 3);
        add_vec(32'h00100093, 32'h00000000, 0, 16,  0, 32'h0,        0,  0, 0, 5, 2, 17);
        add_vec(32'h00100093, 32'h00000000, 0, 15,  0, 32'h4,        1,  1, 0, 0, 0, 20);
        add_vec(32'h00002083, 32'h00000000, 0,  0, 16, 32'h0,        0,  0, 0, 5, 3, 20);
        add_vec(32'h00002083, 32'h00000000, 0,  0, 15, 32'h4,        1,  1, 0, 0, 0, 21);
        add_vec(32'h00112023, 32'h00000000, 0,  0, 16, 32'h0,        0,  0, 16, 5, 3, 20);
        add_vec(32'h000080E7, 32'h00000103, 0,  0,  0, 32'h102,      1,  1, 0, 0, 0, 5);
        add_vec(32'h008000EF, 32'h00000080, 0,  0,  0, 32'h80,       1,  1, 0, 0, 0, 5);
        add_vec(32'h000010B7, 32'h00000000, 0,  2,  0, 32'h4,        1,  1, 0, 0, 0, 7);

        foreach (vecs[i]) begin
            do_reset();
            apply($sformatf("vec%0d", i), vecs[i].instr, vecs[i].alu, vecs[i].bt, vecs[i].di,
                  vecs[i].dd, TB_RESET_PC, vecs[i].e);
        end

        // pc wraps past the top of the address space
        do_reset();
        predict(32'h008000EF, 32'hFFFFFFFC, 0, 0, 0, e);
        apply("wrap_jal", 32'h008000EF, 32'hFFFFFFFC, 0, 0, 0, m_pc, e);
        m_pc = e.pc; m_ret = e.ret;
        predict(32'h00100093, 32'h0, 0, 1, 0, e);
        apply("wrap_addi", 32'h00100093, 32'h0, 0, 1, 0, m_pc, e);
        chk("wrap", "pc_zero", pc, 32'h0);

        // reset during a MEM wait drops the request at once
        do_reset();
        predict(32'h00100093, 32'h0, 0, 0, 0, e);
        apply("pre_mem_rst", 32'h00100093, 32'h0, 0, 0, 0, m_pc, e);
        imem_rdata = 32'h00002083;
        en = 1'b1;
        for (int k = 0; k < 20 && state != 3'd3; k++) begin
            imem_valid = imem_req;
            @(negedge clk);
        end
        imem_valid = 1'b0;
        chk("mem_rst", "reached_mem", state, 3'd3);
        @(negedge clk);
        chk("mem_rst", "dmem_req_waiting", dmem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("mem_rst", "async", {dmem_req, dmem_we, imem_req, reg_we, state, pc, retired},
            {4'b0000, 3'd0, TB_RESET_PC, 32'd0});
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        m_pc = TB_RESET_PC; m_ret = 0; m_trap = 0;

        // no fetch until en is seen high in FETCH
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("en_gate", "idle", {imem_req, state}, {1'b0, 3'd0});
        end
        en = 1'b1;
        @(negedge clk);
        chk("en_gate", "first_fetch", {imem_req, imem_addr}, {1'b1, TB_RESET_PC});

        // randomized instruction stream against the model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            if (m_trap) do_reset();
            instr = $urandom;
            if ($urandom_range(0, 11) == 0) instr[6:0] = ($urandom_range(0, 1) == 0) ?
                                                          7'b1111111 : 7'b0000000;
            else instr[6:0] = legal_ops[$urandom_range(0, 8)];
            di = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 16))
                                               : int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 16))
                                              : int'($urandom_range(0, 3));
            alu_result = $urandom;
            predict(instr, alu_result, 1'($urandom_range(0, 1)), di, dd, e);
            // rebuild with the same branch decision the model saw
            begin
                logic bt;
                logic [31:0] alu;
                bt = 1'($urandom_range(0, 1));
                alu = $urandom;
                predict(instr, alu, bt, di, dd, e);
                apply($sformatf("rand%0d", n), instr, alu, bt, di, dd, m_pc, e);
            end
            m_pc = e.pc; m_ret = e.ret; m_trap = (e.st == 3'd5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
